rtc_calendar_core: RTL and testbench

//   Parametrised time-of-day and calendar counter for the watch datapath.

---
 rtl/rtc_calendar_core.sv | 201 ++++++++++++++++++++
 tb/tb_rtc_calendar_core.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_calendar_core.sv
// -----------------------------------------------------------------------------
// rtc_calendar_core
//   Time-of-day and calendar counter for the watch datapath. A prescaler
//   derives a 1 Hz tick from the system clock, and each tick advances
//   sec/min/hour/day/month/year with month-length and leap-year handling.
//   The block also provides a legality-checked time/date load, a 12/24 h
//   display hour and an hh:mm alarm strobe.
//
// Parameters
//   CLK_HZ     system clock frequency; the prescaler wraps at CLK_HZ-1
//   YEAR_W     width of the year offset from 2000 (legal 0..99)
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   run                       1 = prescaler counts, 0 = time frozen
//   mode_12h                  selects the 12 h format on hour_disp
//   set_valid, set_*          one-cycle load strobe and the fields to load
//   alarm_en, alarm_hour/min  alarm enable and compare value
//   second..year              registered binary time/date
//   hour_disp, pm             combinational display hour and pm flag
//   sec_pulse                 one-cycle strobe per time advance
//   set_err                   one-cycle strobe when a load is rejected
//   alarm_hit                 one-cycle strobe on an alarm match
// -----------------------------------------------------------------------------
module rtc_calendar_core #(
    parameter int CLK_HZ = 50_000_000,
    parameter int YEAR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              mode_12h,
    input  logic              set_valid,
    input  logic [5:0]        set_sec,
    input  logic [5:0]        set_min,
    input  logic [4:0]        set_hour,
    input  logic [4:0]        set_day,
    input  logic [3:0]        set_month,
    input  logic [YEAR_W-1:0] set_year,
    input  logic              alarm_en,
    input  logic [4:0]        alarm_hour,
    input  logic [5:0]        alarm_min,
    output logic [5:0]        second,
    output logic [5:0]        minute,
    output logic [4:0]        hour,
    output logic [4:0]        hour_disp,
    output logic              pm,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic              sec_pulse,
    output logic              set_err,
    output logic              alarm_hit
);

    localparam int                PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0]  PRE_TC   = PRE_W'(CLK_HZ - 1);
    localparam logic [YEAR_W-1:0] YEAR_MAX = YEAR_W'(99);

    // Leap rule year%4==0 holds for every year 2000..2099.
    function automatic logic [4:0] days_in_month(input logic [3:0]        m,
                                                 input logic [YEAR_W-1:0] y);
        logic [4:0] d;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            4'd2:    d = ((y & YEAR_W'(3)) == '0) ? 5'd29 : 5'd28;
            default: d = 5'd31;
        endcase
        return d;
    endfunction

    logic [PRE_W-1:0]  prescaler;
    logic              tick;
    logic              load_legal;
    logic              load_ok;
    logic              load_bad;

    logic [5:0]        sec_nxt;
    logic [5:0]        min_nxt;
    logic [4:0]        hour_nxt;
    logic [4:0]        day_nxt;
    logic [3:0]        month_nxt;
    logic [YEAR_W-1:0] year_nxt;
    logic              alarm_match;

    assign tick = run && (prescaler == PRE_TC);

    always_comb begin
        load_legal = (set_sec   <= 6'd59) &&
                     (set_min   <= 6'd59) &&
                     (set_hour  <= 5'd23) &&
                     (set_month >= 4'd1) && (set_month <= 4'd12) &&
                     (set_year  <= YEAR_MAX) &&
                     (set_day   >= 5'd1) &&
                     (set_day   <= days_in_month(set_month, set_year));
    end

    assign load_ok  = set_valid && load_legal;
    assign load_bad = set_valid && !load_legal;

    // One-second advance of the whole cascade, evaluated every cycle and
    // committed only on a tick that is not overridden by a load.
    always_comb begin
        sec_nxt   = second;
        min_nxt   = minute;
        hour_nxt  = hour;
        day_nxt   = day;
        month_nxt = month;
        year_nxt  = year;

        if (second == 6'd59) begin
            sec_nxt = 6'd0;
            if (minute == 6'd59) begin
                min_nxt = 6'd0;
                if (hour == 5'd23) begin
                    hour_nxt = 5'd0;
                    if (day >= days_in_month(month, year)) begin
                        day_nxt = 5'd1;
                        if (month >= 4'd12) begin
                            month_nxt = 4'd1;
                            year_nxt  = (year >= YEAR_MAX) ? '0 : year + YEAR_W'(1);
                        end else begin
                            month_nxt = month + 4'd1;
                        end
                    end else begin
                        day_nxt = day + 5'd1;
                    end
                end else begin
                    hour_nxt = hour + 5'd1;
                end
            end else begin
                min_nxt = minute + 6'd1;
            end
        end else begin
            sec_nxt = second + 6'd1;
        end
    end

    assign alarm_match = alarm_en &&
                         (hour_nxt == alarm_hour) &&
                         (min_nxt  == alarm_min)  &&
                         (sec_nxt  == 6'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            second    <= 6'd0;
            minute    <= 6'd0;
            hour      <= 5'd0;
            day       <= 5'd1;
            month     <= 4'd1;
            year      <= '0;
            sec_pulse <= 1'b0;
            set_err   <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            sec_pulse <= 1'b0;
            alarm_hit <= 1'b0;
            set_err   <= load_bad;

            if (load_ok) begin
                // A legal load wins over a coincident tick; that tick is lost.
                prescaler <= '0;
                second    <= set_sec;
                minute    <= set_min;
                hour      <= set_hour;
                day       <= set_day;
                month     <= set_month;
                year      <= set_year;
            end else begin
                if (run) begin
                    prescaler <= tick ? '0 : prescaler + PRE_W'(1);
                end
                if (tick) begin
                    second    <= sec_nxt;
                    minute    <= min_nxt;
                    hour      <= hour_nxt;
                    day       <= day_nxt;
                    month     <= month_nxt;
                    year      <= year_nxt;
                    sec_pulse <= 1'b1;
                    alarm_hit <= alarm_match;
                end
            end
        end
    end

    always_comb begin
        hour_disp = hour;
        if (mode_12h) begin
            if (hour == 5'd0) begin
                hour_disp = 5'd12;
            end else if (hour > 5'd12) begin
                hour_disp = hour - 5'd12;
            end
        end
    end

    assign pm = (hour >= 5'd12);

endmodule

// File: tb/tb_rtc_calendar_core.sv
// -----------------------------------------------------------------------------
// tb_rtc_calendar_core
//   Directed bench for rtc_calendar_core with CLK_HZ=4 (one tick every four
//   enabled cycles). Inputs change 1 time unit after a rising edge and
//   outputs are sampled at the same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_rtc_calendar_core;

    localparam int CLK_HZ = 4;
    localparam int YEAR_W = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic              mode_12h;
    logic              set_valid;
    logic [5:0]        set_sec;
    logic [5:0]        set_min;
    logic [4:0]        set_hour;
    logic [4:0]        set_day;
    logic [3:0]        set_month;
    logic [YEAR_W-1:0] set_year;
    logic              alarm_en;
    logic [4:0]        alarm_hour;
    logic [5:0]        alarm_min;
    logic [5:0]        second;
    logic [5:0]        minute;
    logic [4:0]        hour;
    logic [4:0]        hour_disp;
    logic              pm;
    logic [4:0]        day;
    logic [3:0]        month;
    logic [YEAR_W-1:0] year;
    logic              sec_pulse;
    logic              set_err;
    logic              alarm_hit;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;

    rtc_calendar_core #(.CLK_HZ(CLK_HZ), .YEAR_W(YEAR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .mode_12h   (mode_12h),
        .set_valid  (set_valid),
        .set_sec    (set_sec),
        .set_min    (set_min),
        .set_hour   (set_hour),
        .set_day    (set_day),
        .set_month  (set_month),
        .set_year   (set_year),
        .alarm_en   (alarm_en),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .second     (second),
        .minute     (minute),
        .hour       (hour),
        .hour_disp  (hour_disp),
        .pm         (pm),
        .day        (day),
        .month      (month),
        .year       (year),
        .sec_pulse  (sec_pulse),
        .set_err    (set_err),
        .alarm_hit  (alarm_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int h, input int mi, input int s,
                        input int d, input int mo, input int y);
        set_hour  = 5'(h);
        set_min   = 6'(mi);
        set_sec   = 6'(s);
        set_day   = 5'(d);
        set_month = 4'(mo);
        set_year  = YEAR_W'(y);
        set_valid = 1'b1;
        step(1);
        set_valid = 1'b0;
    endtask

    task automatic check_time(input string tag, input int h, input int mi, input int s,
                              input int d, input int mo, input int y);
        check({tag, ".hour"},  32'(hour),   32'(h));
        check({tag, ".min"},   32'(minute), 32'(mi));
        check({tag, ".sec"},   32'(second), 32'(s));
        check({tag, ".day"},   32'(day),    32'(d));
        check({tag, ".month"}, 32'(month),  32'(mo));
        check({tag, ".year"},  32'(year),   32'(y));
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; mode_12h = 1'b0; set_valid = 1'b0;
        set_sec = '0; set_min = '0; set_hour = '0; set_day = 5'd1;
        set_month = 4'd1; set_year = '0;
        alarm_en = 1'b0; alarm_hour = '0; alarm_min = '0;

        // 1. reset state and first tick latency
        step(2);
        rst = 1'b0;
        check_time("rst", 0, 0, 0, 1, 1, 0);
        check("rst.sec_pulse", 32'(sec_pulse), 0);
        check("rst.set_err",   32'(set_err),   0);
        check("rst.alarm_hit", 32'(alarm_hit), 0);
        run = 1'b1;
        step(3);
        check("first.no_pulse_yet", 32'(sec_pulse), 0);
        step(1);
        check("first.pulse", 32'(sec_pulse), 1);
        check("first.sec",   32'(second),    1);

        // 2. full rollover at end of century
        run = 1'b0;
        load(23, 59, 59, 31, 12, 99);
        run = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (sec_pulse) pulses++;
        end
        check("roll.pulses", 32'(pulses), 1);
        check_time("roll", 0, 0, 0, 1, 1, 0);

        // 3. leap-year February handling
        load(23, 59, 59, 28, 2, 24);
        step(4);
        check_time("leap24", 0, 0, 0, 29, 2, 24);
        load(23, 59, 59, 28, 2, 23);
        step(4);
        check_time("feb23", 0, 0, 0, 1, 3, 23);
        run = 1'b0;
        load(0, 0, 0, 29, 2, 23);
        check("feb29_23.set_err", 32'(set_err), 1);
        check_time("feb29_23.held", 0, 0, 0, 1, 3, 23);

        // 4. illegal loads leave the time untouched
        load(10, 20, 30, 15, 6, 10);
        check("legal.set_err", 32'(set_err), 0);
        load(12, 0, 0, 31, 4, 10);
        check("apr31.set_err", 32'(set_err), 1);
        check_time("apr31.held", 10, 20, 30, 15, 6, 10);
        step(1);
        check("apr31.err_one_cycle", 32'(set_err), 0);
        load(24, 0, 0, 1, 1, 10);
        check("hour24.set_err", 32'(set_err), 1);
        check("hour24.held", 32'(hour), 10);

        // 5. alarm and 12 h display
        alarm_hour = 5'd7; alarm_min = 6'd30; alarm_en = 1'b1;
        load(7, 29, 59, 1, 1, 0);
        check("alarm.load_no_hit", 32'(alarm_hit), 0);
        run = 1'b1;
        step(3);
        check("alarm.early", 32'(alarm_hit), 0);
        step(1);
        check("alarm.hit",   32'(alarm_hit), 1);
        check("alarm.pulse", 32'(sec_pulse), 1);
        check("alarm.min",   32'(minute),    30);
        check("alarm.sec",   32'(second),    0);
        step(1);
        check("alarm.one_cycle", 32'(alarm_hit), 0);
        run = 1'b0;
        load(7, 30, 0, 1, 1, 0);
        check("alarm.load_exact_no_hit", 32'(alarm_hit), 0);
        alarm_en = 1'b0;
        load(7, 29, 59, 1, 1, 0);
        run = 1'b1;
        step(4);
        check("alarm_off.pulse", 32'(sec_pulse), 1);
        check("alarm_off.no_hit", 32'(alarm_hit), 0);
        run = 1'b0;
        load(0, 0, 0, 1, 1, 0);
        mode_12h = 1'b1;
        #1;
        check("h0.disp12", 32'(hour_disp), 12);
        check("h0.pm",     32'(pm),        0);
        mode_12h = 1'b0;
        #1;
        check("h0.disp24", 32'(hour_disp), 0);
        mode_12h = 1'b1;
        load(13, 0, 0, 1, 1, 0);
        check("h13.disp12", 32'(hour_disp), 1);
        check("h13.pm",     32'(pm),        1);
        load(12, 0, 0, 1, 1, 0);
        check("h12.disp12", 32'(hour_disp), 12);
        check("h12.pm",     32'(pm),        1);
        load(11, 0, 0, 1, 1, 0);
        check("h11.disp12", 32'(hour_disp), 11);
        check("h11.pm",     32'(pm),        0);
        mode_12h = 1'b0;
        load(23, 0, 0, 1, 1, 0);
        check("h23.disp24", 32'(hour_disp), 23);

        // 6. load coinciding with prescaler wrap, then reset mid-count
        load(1, 2, 3, 1, 1, 0);
        run = 1'b1;
        step(3);
        load(5, 6, 7, 2, 3, 4);
        check("wrap.no_pulse", 32'(sec_pulse), 0);
        check_time("wrap.loaded", 5, 6, 7, 2, 3, 4);
        step(3);
        check("wrap.no_early_pulse", 32'(sec_pulse), 0);
        step(1);
        check("wrap.next_pulse", 32'(sec_pulse), 1);
        check("wrap.next_sec",   32'(second),    8);
        step(2);
        rst = 1'b1;
        set_hour = 5'd9; set_min = 6'd9; set_sec = 6'd9;
        set_day = 5'd9; set_month = 4'd9; set_year = YEAR_W'(9);
        set_valid = 1'b1;
        step(1);
        rst = 1'b0;
        set_valid = 1'b0;
        check_time("midrst", 0, 0, 0, 1, 1, 0);
        check("midrst.pulse", 32'(sec_pulse), 0);
        step(3);
        check("midrst.no_pulse_yet", 32'(sec_pulse), 0);
        step(1);
        check("midrst.pulse_after4", 32'(sec_pulse), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
